// File: rtl/cache_mem_itf_pkg.sv
// ---------------------------------------------------------------------------
// cache_mem_itf -- shared widths and types for the cache <-> memory line
// interface. Both the cache controller side and cacheline_adaptor import this
// package so line and beat widths can never drift apart.
//
//   LINE_W      cacheline width in bits (256)
//   BURST_W     memory beat width in bits (64)
//   BEATS       beats per line, derived (4)
//   BEAT_IDX_W  width of a beat index (2)
//   state_t     adaptor FSM states
//   line_t      one cacheline
//   beat_t      one memory beat
//   beat_idx_t  beat position inside a line
// ---------------------------------------------------------------------------
package cache_mem_itf;

    localparam int LINE_W     = 256;
    localparam int BURST_W    = 64;
    localparam int BEATS      = LINE_W / BURST_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef logic [LINE_W-1:0]     line_t;
    typedef logic [BURST_W-1:0]    beat_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

endpackage : cache_mem_itf

// File: rtl/cacheline_adaptor_beat_buf.sv
// ---------------------------------------------------------------------------
// cacheline_beat_buf -- line storage for both burst directions.
//
// Holds the line being assembled from read beats and, separately, the line
// latched for a write burst, so a write never disturbs the last read line.
//
//   clk       clock
//   rst_n     asynchronous active-low reset
//   load      capture line_in as the write line
//   line_in   line to be written to memory
//   beat_we   store beat_in into the read line at beat_idx
//   beat_idx  current beat position
//   beat_in   beat returned by memory
//   line_out  assembled read line
//   beat_out  write-line beat selected by beat_idx
// ---------------------------------------------------------------------------
module cacheline_beat_buf
    import cache_mem_itf::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  line_t     line_in,
    input  logic      beat_we,
    input  beat_idx_t beat_idx,
    input  beat_t     beat_in,
    output line_t     line_out,
    output beat_t     beat_out
);

    line_t rd_line_q;
    line_t wr_line_q;

    // NOTE: these wide registers are reset on purpose: line_o and burst_o
    // must read zero after reset, including after an aborted burst.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_line_q <= '0;
            wr_line_q <= '0;
        end else begin
            if (load) begin
                wr_line_q <= line_in;
            end
            if (beat_we) begin
                rd_line_q[beat_idx*BURST_W +: BURST_W] <= beat_in;
            end
        end
    end

    assign line_out = rd_line_q;
    assign beat_out = wr_line_q[beat_idx*BURST_W +: BURST_W];

endmodule : cacheline_beat_buf

// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor -- converts one 256-bit cacheline read/write request into
// a 4-beat, 64-bit burst toward physical memory and answers the cache with a
// single-cycle resp_o per completed (or aborted) line.
//
// Parameters
//   ADDR_W    byte address width
//   TIMEOUT   watchdog limit in cycles (only with CACHELINE_ADAPTOR_WDT_EN)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   read_i, write_i       line requests from cache, held until resp_o
//   address_i             line address from cache
//   line_i                write line from cache
//   line_o                assembled read line
//   resp_o                one-cycle completion pulse to cache
//   address_o             line-aligned burst address
//   read_o, write_o       burst requests to memory
//   burst_o               write beat data
//   burst_i               read beat data
//   resp_i                memory beat-valid / beat-accepted strobe
//   err_o                 watchdog abort pulse
//
// Build option
//   CACHELINE_ADAPTOR_WDT_EN  enables the burst watchdog; when undefined a
//   burst waits indefinitely for resp_i and err_o is constant 0.
// ---------------------------------------------------------------------------
module cacheline_adaptor
    import cache_mem_itf::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  line_t             line_i,
    output line_t             line_o,
    output logic              resp_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    output beat_t             burst_o,
    input  beat_t             burst_i,
    input  logic              resp_i,
    output logic              err_o
);

    // Low address bits that select a byte inside one line.
    localparam logic [ADDR_W-1:0] LINE_OFS_MASK = ADDR_W'(LINE_W/8 - 1);

    state_t            state_q, state_d;
    beat_idx_t         beat_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_rd, start_wr, start;
    logic              busy, beat_acc, last_beat;
    logic              wdt_hit;

    assign busy      = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign beat_acc  = busy && resp_i;
    assign last_beat = beat_q == beat_idx_t'(BEATS - 1);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Both requests high is treated as no request.
                if (read_i && !write_i) begin
                    start_rd = 1'b1;
                    state_d  = RD_BURST;
                end else if (write_i && !read_i) begin
                    start_wr = 1'b1;
                    state_d  = WR_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if ((resp_i && last_beat) || wdt_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign start = start_rd || start_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q <= address_i & ~LINE_OFS_MASK;
                beat_q <= '0;
            end else if (beat_acc) begin
                // Wraps 3 -> 0 exactly on the final accepted beat.
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    cacheline_beat_buf u_beat_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_wr),
        .line_in  (line_i),
        .beat_we  ((state_q == RD_BURST) && resp_i),
        .beat_idx (beat_q),
        .beat_in  (burst_i),
        .line_out (line_o),
        .beat_out (burst_o)
    );

`ifdef CACHELINE_ADAPTOR_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT + 1);

    logic [WDT_W-1:0] wdt_q;
    logic             err_q;

    // Fires on the TIMEOUT-th consecutive idle burst cycle; the abort then
    // reuses DONE so the cache still sees exactly one resp_o.
    assign wdt_hit = busy && !resp_i && (wdt_q == WDT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start || beat_acc) begin
                wdt_q <= '0;
            end else if (busy) begin
                wdt_q <= wdt_q + 1'b1;
            end
            // Registered so err_o lines up with the DONE-cycle resp_o.
            err_q <= wdt_hit;
        end
    end

    assign err_o = err_q;
`else
    assign wdt_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign read_o    = (state_q == RD_BURST);
    assign write_o   = (state_q == WR_BURST);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;
    import cache_mem_itf::*;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              read_i, write_i, resp_i;
    logic [ADDR_W-1:0] address_i;
    line_t             line_i;
    line_t             line_o;
    logic              resp_o, read_o, write_o, err_o;
    logic [ADDR_W-1:0] address_o;
    beat_t             burst_o, burst_i;

    cacheline_adaptor #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_i    (read_i),
        .write_i   (write_i),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [63:0]  beats [4];
        logic [7:0]   mask;       // bit i: resp_i offered in burst cycle i
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
        int           exp_lat;    // cycles from request to resp_o
    } rd_vec_t;

    rd_vec_t vec [3];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_read(input rd_vec_t v, input string tag);
        int cyc;
        int k;
        int idx;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = v.addr;
        resp_i    = 1'b0;
        step();
        cyc = 1;
        check({tag, " read_o"}, 256'(read_o), 256'(1));
        check({tag, " address_o"}, 256'(address_o), 256'(v.exp_addr));
        k   = 0;
        idx = 0;
        while (!resp_o && cyc < 60) begin
            if (k < 4 && (idx >= 8 || v.mask[idx])) begin
                resp_i  = 1'b1;
                burst_i = v.beats[k];
                k++;
            end else begin
                resp_i = 1'b0;
            end
            idx++;
            step();
            cyc++;
        end
        resp_i = 1'b0;
        check({tag, " latency"}, 256'(cyc), 256'(v.exp_lat));
        check({tag, " resp_o"}, 256'(resp_o), 256'(1));
        check({tag, " read_o done"}, 256'(read_o), 256'(0));
        check({tag, " line_o"}, line_o, v.exp_line);
        read_i = 1'b0;
        step();
        check({tag, " resp_o pulse"}, 256'(resp_o), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int seen;

        vec[0].addr = 32'h1234_5678; vec[0].mask = 8'hFF;
        vec[0].beats[0] = 64'h1111_1111_1111_1111;
        vec[0].beats[1] = 64'h2222_2222_2222_2222;
        vec[0].beats[2] = 64'h3333_3333_3333_3333;
        vec[0].beats[3] = 64'h4444_4444_4444_4444;
        vec[0].exp_addr = 32'h1234_5660; vec[0].exp_lat = 5;
        vec[0].exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

        vec[1].addr = 32'hFFFF_FFFF; vec[1].mask = 8'b1010_1010;
        vec[1].beats[0] = 64'h0123_4567_89AB_CDEF;
        vec[1].beats[1] = 64'hFEDC_BA98_7654_3210;
        vec[1].beats[2] = 64'h0000_0000_FFFF_FFFF;
        vec[1].beats[3] = 64'hA5A5_A5A5_5A5A_5A5A;
        vec[1].exp_addr = 32'hFFFF_FFE0; vec[1].exp_lat = 9;
        vec[1].exp_line = {64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_FFFF_FFFF,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

        vec[2].addr = 32'h0000_001F; vec[2].mask = 8'b1111_1100;
        vec[2].beats[0] = 64'hDEAD_BEEF_0000_0001;
        vec[2].beats[1] = 64'hDEAD_BEEF_0000_0002;
        vec[2].beats[2] = 64'hDEAD_BEEF_0000_0003;
        vec[2].beats[3] = 64'hDEAD_BEEF_0000_0004;
        vec[2].exp_addr = 32'h0000_0000; vec[2].exp_lat = 7;
        vec[2].exp_line = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                           64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};

        // Reset state.
        rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        #12;
        check("rst line_o", line_o, 256'(0));
        check("rst address_o", 256'(address_o), 256'(0));
        check("rst burst_o", 256'(burst_o), 256'(0));
        check("rst ctl", 256'({read_o, write_o, resp_o, err_o}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven reads.
        for (int i = 0; i < 3; i++) begin
            run_read(vec[i], $sformatf("rd%0d", i));
        end

        // Gapped write; line_o must keep the last read line.
        write_i   = 1'b1;
        address_i = 32'h8000_0044;
        line_i    = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                     64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        step();
        check("wr write_o", 256'(write_o), 256'(1));
        check("wr address_o", 256'(address_o), 256'(32'h8000_0040));
        check("wr beat0", 256'(burst_o), 256'(64'hD0D0_D0D0_D0D0_D0D0));
        resp_i = 1'b1; step();
        check("wr beat1", 256'(burst_o), 256'(64'hD1D1_D1D1_D1D1_D1D1));
        resp_i = 1'b0; step();
        check("wr beat1 hold", 256'(burst_o), 256'(64'hD1D1_D1D1_D1D1_D1D1));
        resp_i = 1'b1; step();
        check("wr beat2", 256'(burst_o), 256'(64'hD2D2_D2D2_D2D2_D2D2));
        resp_i = 1'b0; step();
        check("wr beat2 hold", 256'(burst_o), 256'(64'hD2D2_D2D2_D2D2_D2D2));
        check("wr no early resp", 256'(resp_o), 256'(0));
        resp_i = 1'b1; step();
        check("wr beat3", 256'(burst_o), 256'(64'hD3D3_D3D3_D3D3_D3D3));
        resp_i = 1'b1; step();
        resp_i = 1'b0;
        check("wr resp_o", 256'(resp_o), 256'(1));
        check("wr write_o done", 256'(write_o), 256'(0));
        check("wr line_o kept", line_o, vec[2].exp_line);
        write_i = 1'b0; step();
        check("wr resp_o pulse", 256'(resp_o), 256'(0));

        // Conflicting requests, then stray resp_i in IDLE.
        read_i = 1'b1; write_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("both%0d ctl", i), 256'({read_o, write_o, resp_o}), 256'(0));
        end
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("stray%0d ctl", i), 256'({read_o, write_o, resp_o}), 256'(0));
        end
        resp_i = 1'b0;
        check("stray line_o", line_o, vec[2].exp_line);

        // Reset in the middle of a read after three beats.
        read_i = 1'b1; address_i = 32'h0000_ABCD;
        step();
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1; burst_i = vec[0].beats[i];
            step();
        end
        resp_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort ctl", 256'({read_o, write_o, resp_o, err_o}), 256'(0));
        check("abort line_o", line_o, 256'(0));
        check("abort address_o", 256'(address_o), 256'(0));
        read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("abort idle", 256'({read_o, write_o, resp_o}), 256'(0));
        run_read(vec[1], "post_rst");

        // Stalled burst with no resp_i.
        read_i = 1'b1; address_i = 32'h0000_0100;
        step();
        seen = 0;
`ifdef CACHELINE_ADAPTOR_WDT_EN
        begin
            int cyc;
            cyc = 1;
            while (!resp_o && cyc < 60) begin
                step();
                cyc++;
            end
            check("wdt latency", 256'(cyc), 256'(17));
            check("wdt err_o", 256'(err_o), 256'(1));
            check("wdt resp_o", 256'(resp_o), 256'(1));
            read_i = 1'b0;
            step();
            check("wdt err_o pulse", 256'({err_o, resp_o}), 256'(0));
        end
`else
        for (int i = 0; i < 40; i++) begin
            step();
            if (resp_o || err_o) seen++;
        end
        check("stall no resp", 256'(seen), 256'(0));
        check("stall read_o", 256'(read_o), 256'(1));
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b1; burst_i = vec[0].beats[i];
            step();
        end
        resp_i = 1'b0;
        check("stall resp_o", 256'(resp_o), 256'(1));
        check("stall line_o", line_o, vec[0].exp_line);
        read_i = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cacheline_adaptor
